cordiccart2pol_vec_iter: RTL and testbench

- Iterative CORDIC vectoring engine for the cart2pol path.
- Accepts one signed Cartesian sample (x, y) and runs NUM_ITER shift-add micro-rotations, one per clock.
- Emits the un-normalised magnitude (still carries CORDIC gain K≈1.647) and the angle in binary angle units (BAM).
- Sits directly upstream of the gain-compensation multiplier, which scales mag_out by 1/K.

---
 rtl/cordiccart2pol_vec_iter.sv | 129 ++++++++++++
 tb/tb_cordiccart2pol_vec_iter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/cordiccart2pol_vec_iter.sv
// Iterative CORDIC vectoring engine: (x, y) -> (K*|v|, angle in BAM), one micro-rotation per clock.
// Optional macro CORDICCART2POL_VEC_BTB_EN lets a new sample load on the edge the result is consumed.
module cordiccart2pol_vec_iter #(
   parameter int DATA_W   = 8,
   parameter int ANG_W    = 8,
   parameter int NUM_ITER = 6
) (
   input  logic                     ap_clk,
   input  logic                     ap_rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DATA_W-1:0] x_in,
   input  logic signed [DATA_W-1:0] y_in,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_W+1:0]        mag_out,
   output logic signed [ANG_W-1:0]  theta_out
);

   localparam int W = DATA_W + 2;
   localparam logic [3:0] LAST = 4'(NUM_ITER - 1);

   // atan(2^-i) in 16-bit BAM; rescaled to ANG_W with round-half-up
   localparam logic [15:0] ATAN_T [16] = '{
      16'd8192, 16'd4836, 16'd2555, 16'd1297, 16'd651, 16'd326, 16'd163, 16'd81,
      16'd41,   16'd20,   16'd10,   16'd5,    16'd3,   16'd1,   16'd1,   16'd0
   };

   typedef enum logic [1:0] {IDLE, ROTATE, DONE} state_t;

   state_t                state_q, state_d;
   logic signed [W-1:0]   x_q, x_d, y_q, y_d;
   logic [ANG_W-1:0]      z_q, z_d;
   logic [3:0]            i_q, i_d;
   logic [W-1:0]          mag_q, mag_d;
   logic [ANG_W-1:0]      theta_q, theta_d;

   logic signed [W-1:0]   x_ext, y_ext, x_sh, y_sh;
   logic [ANG_W-1:0]      atan, pi_bam;
   logic                  accept;

   assign x_ext  = {{2{x_in[DATA_W-1]}}, x_in};
   assign y_ext  = {{2{y_in[DATA_W-1]}}, y_in};
   assign x_sh   = x_q >>> i_q;
   assign y_sh   = y_q >>> i_q;
   assign pi_bam = {1'b1, {(ANG_W-1){1'b0}}};
   assign atan   = ANG_W'((int'(ATAN_T[i_q]) + (32768 >> ANG_W)) >> (16 - ANG_W));

`ifdef CORDICCART2POL_VEC_BTB_EN
   assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
`else
   assign in_ready = (state_q == IDLE);
`endif

   assign accept    = in_valid && in_ready;
   assign out_valid = (state_q == DONE);
   assign mag_out   = mag_q;
   assign theta_out = theta_q;

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      z_d     = z_q;
      i_d     = i_q;
      mag_d   = mag_q;
      theta_d = theta_q;
      unique case (state_q)
         IDLE: begin
         end
         ROTATE: begin
            if (!y_q[W-1]) begin
               x_d = x_q + y_sh;
               y_d = y_q - x_sh;
               z_d = z_q + atan;
            end else begin
               x_d = x_q - y_sh;
               y_d = y_q + x_sh;
               z_d = z_q - atan;
            end
            i_d = i_q + 4'd1;
            if (i_q == LAST) begin
               state_d = DONE;
               mag_d   = x_d;
               theta_d = z_d;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Left half-plane is folded into the right by a pi rotation
      if (accept) begin
         state_d = ROTATE;
         i_d     = 4'd0;
         if (x_in[DATA_W-1]) begin
            x_d = -x_ext;
            y_d = -y_ext;
            z_d = pi_bam;
         end else begin
            x_d = x_ext;
            y_d = y_ext;
            z_d = '0;
         end
      end
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state_q <= IDLE;
         x_q     <= '0;
         y_q     <= '0;
         z_q     <= '0;
         i_q     <= '0;
         mag_q   <= '0;
         theta_q <= '0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         z_q     <= z_d;
         i_q     <= i_d;
         mag_q   <= mag_d;
         theta_q <= theta_d;
      end
   end

endmodule

// File: tb/tb_cordiccart2pol_vec_iter.sv
// Directed bench for cordiccart2pol_vec_iter at default parameters.
// Expected results are hand-worked shift-add traces with floor shifts.
module tb_cordiccart2pol_vec_iter;

   localparam int DW = 8;
   localparam int AW = 8;
`ifdef CORDICCART2POL_VEC_BTB_EN
   localparam int PERIOD = 7;
`else
   localparam int PERIOD = 8;
`endif

   logic                 ap_clk = 1'b0;
   logic                 ap_rst_n = 1'b0;
   logic                 in_valid = 1'b0;
   logic                 out_ready = 1'b1;
   logic                 in_ready;
   logic                 out_valid;
   logic signed [DW-1:0] x_in = '0;
   logic signed [DW-1:0] y_in = '0;
   logic [DW+1:0]        mag_out;
   logic signed [AW-1:0] theta_out;

   int n_chk = 0;
   int n_fail = 0;

   always #5 ap_clk = ~ap_clk;

   cordiccart2pol_vec_iter #(.DATA_W(DW), .ANG_W(AW), .NUM_ITER(6)) dut (
      .ap_clk    (ap_clk),
      .ap_rst_n  (ap_rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x_in      (x_in),
      .y_in      (y_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .mag_out   (mag_out),
      .theta_out (theta_out)
   );

   task automatic check(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic start(input int x, input int y);
      check("start_rdy", int'(in_ready), 1);
      x_in     = DW'(x);
      y_in     = DW'(y);
      in_valid = 1'b1;
      @(posedge ap_clk);
      #1;
      in_valid = 1'b0;
   endtask

   // edges counted with the accepting edge as 1
   task automatic wait_res(output int edges);
      edges = 1;
      while (!out_valid && edges < 40) begin
         @(posedge ap_clk);
         #1;
         edges++;
      end
   endtask

   task automatic sample(input string tag, input int x, input int y,
                         input int emag, input int eth);
      int e;
      start(x, y);
      wait_res(e);
      check({tag, "_lat"}, e, 7);
      check({tag, "_mag"}, int'(mag_out), emag);
      check({tag, "_th"}, int'(theta_out), eth);
      @(posedge ap_clk);
      #1;
      check({tag, "_idle"}, int'(in_ready && !out_valid), 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int e;
      int vx[4] = '{100, 0, -100, 0};
      int vy[4] = '{0, 100, 0, -100};
      int em[4] = '{166, 164, 166, 166};
      int et[4] = '{0, 64, -128, -64};
      int tres[4] = '{0, 0, 0, 0};
      int ni, nr;
      bit acc;

      repeat (3) @(posedge ap_clk);
      #1;
      check("rst_in_ready", int'(in_ready), 1);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_mag", int'(mag_out), 0);
      check("rst_theta", int'(theta_out), 0);
      @(negedge ap_clk);
      ap_rst_n = 1'b1;
      @(posedge ap_clk);
      #1;

      sample("p100", 100, 0, 166, 0);
      sample("n100", -100, 0, 166, -128);
      sample("n128", -128, 0, 211, -128);
      sample("zero", 0, 0, 0, 70);
      sample("ny100", 0, -100, 166, -64);

      // reset while rotating at i=3
      start(50, 30);
      repeat (3) begin
         @(posedge ap_clk);
         #1;
      end
      ap_rst_n = 1'b0;
      repeat (2) @(posedge ap_clk);
      #1;
      check("mid_rst_out_valid", int'(out_valid), 0);
      check("mid_rst_mag", int'(mag_out), 0);
      check("mid_rst_theta", int'(theta_out), 0);
      check("mid_rst_in_ready", int'(in_ready), 1);
      @(negedge ap_clk);
      ap_rst_n = 1'b1;
      @(posedge ap_clk);
      #1;
      sample("post_rst", 100, 0, 166, 0);
      sample("py100", 0, 100, 164, 64);

      // downstream stall with in_valid pulses
      out_ready = 1'b0;
      start(100, 0);
      wait_res(e);
      check("stall_lat", e, 7);
      for (int k = 0; k < 10; k++) begin
         in_valid = k[0];
         x_in     = 8'sd5;
         y_in     = 8'sd7;
         @(posedge ap_clk);
         #1;
         check("stall_hold", int'({out_valid, in_ready, mag_out, theta_out}),
               int'({1'b1, 1'b0, 10'd166, 8'd0}));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge ap_clk);
      #1;
      check("stall_release", int'(in_ready && !out_valid), 1);

      // back-to-back stream
      ni = 0;
      nr = 0;
      x_in = DW'(vx[0]);
      y_in = DW'(vy[0]);
      in_valid = 1'b1;
      for (int c = 0; c < 100 && nr < 4; c++) begin
         acc = in_valid && in_ready;
         @(posedge ap_clk);
         #1;
         if (acc) begin
            ni++;
            if (ni < 4) begin
               x_in = DW'(vx[ni]);
               y_in = DW'(vy[ni]);
            end else begin
               in_valid = 1'b0;
            end
         end
         if (out_valid) begin
            tres[nr] = c;
            check($sformatf("tp%0d_mag", nr), int'(mag_out), em[nr]);
            check($sformatf("tp%0d_th", nr), int'(theta_out), et[nr]);
            nr++;
         end
      end
      in_valid = 1'b0;
      check("tp_count", nr, 4);
      for (int k = 1; k < 4; k++)
         check($sformatf("tp_gap%0d", k), tres[k] - tres[k-1], PERIOD);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
